// File: rtl/vehicle_detector.sv
// vehicle_detector: conditions the raw country-road inductive-loop sensor into
// the clean presence signal X for the traffic-light controller.
// Two-flop synchroniser, rising-edge debounce, gap bridging between queued
// vehicles and stuck-high detection that fails safe with X held high.
// Optional feature macro: VEHICLE_COUNT_EN (adds vehicle_count / count_clr).
module vehicle_detector #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES     = 3,
    parameter int unsigned STUCK_CYCLES    = 64,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             loop_raw,
`ifdef VEHICLE_COUNT_EN
    input  logic             count_clr,
    output logic [CNT_W-1:0] vehicle_count,
`endif
    output logic             X,
    output logic             sensor_fault
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        PRESENT = 3'd2,
        HOLD    = 3'd3,
        FAULT   = 3'd4
    } state_t;

    localparam logic [7:0]  DEB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_CYCLES - 1);
    localparam logic [15:0] STUCK_LAST = 16'(STUCK_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  rc_q, rc_d;
    logic [15:0] sc_q, sc_d;
    logic        s1, s;
    logic        x_d, fault_d;

    // State register, counters, synchroniser and registered outputs
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            s1           <= 1'b0;
            s            <= 1'b0;
            state_q      <= IDLE;
            rc_q         <= '0;
            sc_q         <= '0;
            X            <= 1'b0;
            sensor_fault <= 1'b0;
        end else begin
            s1           <= loop_raw;
            s            <= s1;
            state_q      <= state_d;
            rc_q         <= rc_d;
            sc_q         <= sc_d;
            X            <= x_d;
            sensor_fault <= fault_d;
        end
    end

    // Next-state logic with run counter and stuck counter updates.
    // Single-cycle debounce/hold settings skip ARM/HOLD so the edge latency
    // stays at N+2 for every legal parameter value.
    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        sc_d    = sc_q;
        case (state_q)
            IDLE: begin
                rc_d = '0;
                sc_d = '0;
                if (s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = PRESENT;
                    end else begin
                        state_d = ARM;
                        rc_d    = 8'd1;
                    end
                end
            end
            ARM: begin
                sc_d = '0;
                if (!s) begin
                    state_d = IDLE;
                    rc_d    = '0;
                end else if (rc_q == DEB_LAST) begin
                    state_d = PRESENT;
                    rc_d    = '0;
                end else begin
                    rc_d = rc_q + 8'd1;
                end
            end
            PRESENT: begin
                rc_d = '0;
                if (!s) begin
                    sc_d = '0;
                    if (HOLD_CYCLES == 1) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                        rc_d    = 8'd1;
                    end
                end else if (sc_q == STUCK_LAST) begin
                    state_d = FAULT;
                    sc_d    = '0;
                end else begin
                    sc_d = sc_q + 16'd1;
                end
            end
            HOLD: begin
                sc_d = '0;
                if (s) begin
                    state_d = PRESENT;
                    rc_d    = '0;
                end else if (rc_q == HOLD_LAST) begin
                    state_d = IDLE;
                    rc_d    = '0;
                end else begin
                    rc_d = rc_q + 8'd1;
                end
            end
            FAULT: begin
                sc_d = '0;
                if (s) begin
                    rc_d = '0;
                end else if (rc_q == DEB_LAST) begin
                    state_d = IDLE;
                    rc_d    = '0;
                end else begin
                    rc_d = rc_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                rc_d    = '0;
                sc_d    = '0;
            end
        endcase
    end

    // Output decode from the next state so X/sensor_fault come straight off flops
    always_comb begin
        x_d     = (state_d == PRESENT) || (state_d == HOLD) || (state_d == FAULT);
        fault_d = (state_d == FAULT);
    end

`ifdef VEHICLE_COUNT_EN
    // Saturating arrival counter; only fresh ARM->PRESENT arrivals count
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            vehicle_count <= '0;
        end else if (count_clr) begin
            vehicle_count <= '0;
        end else if (state_q == ARM && state_d == PRESENT && vehicle_count != '1) begin
            vehicle_count <= vehicle_count + 1'b1;
        end
    end
`endif

endmodule

// File: doc/vehicle_detector.md
Name: vehicle_detector

Overview:
- Conditions the raw inductive-loop sensor on the country road into the clean presence signal `X` consumed by the traffic-light signal controller.
- Synchronises the asynchronous loop input and debounces its rising edge.
- Bridges short gaps between queued vehicles so the country-road green is not dropped early.
- Detects a stuck-high loop and fails safe by holding presence asserted.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronised-high cycles required before presence asserts (1..255).
- HOLD_CYCLES, 3, consecutive synchronised-low cycles required before presence deasserts (1..255).
- STUCK_CYCLES, 64, consecutive synchronised-high cycles while present that declare a stuck sensor (must be > DEBOUNCE_CYCLES, <= 65535).
- CNT_W, 8, width of vehicle event counter.

Ports:
- clock  input  1  system clock, rising edge.
- clear  input  1  asynchronous, active-low reset.
- loop_raw  input  1  raw loop sensor, asynchronous to clock, may glitch.
- X  output  1  debounced vehicle-on-country-road presence; drives the controller's X input.
- sensor_fault  output  1  high while the stuck-sensor condition is active.
- vehicle_count  output  CNT_W  vehicle arrival events, saturating (VEHICLE_COUNT_EN only).
- count_clr  input  1  synchronous clear of vehicle_count (VEHICLE_COUNT_EN only).

Behaviour:
- Reset (clear=0, asynchronous) forces all of the following to zero until clear releases:
  - sync flops, state=IDLE, run counter, stuck counter.
  - outputs X=0, sensor_fault=0, vehicle_count=0.
- Synchroniser: two flops, loop_raw -> s1 -> s. All decisions use s. loop_raw-to-s latency is 2 edges.
- Run counter `rc` (8 bit) counts consecutive cycles of s at the level that would cause the next transition. It clears on every state change and whenever s returns to the current stable level.
- States and transitions (evaluated each rising edge):
  - IDLE (X=0): s=1 -> ARM, rc=1.
  - ARM (X=0):
    - s=0 -> IDLE (glitch rejected).
    - s=1 and rc==DEBOUNCE_CYCLES-1 -> PRESENT.
    - else rc++.
  - PRESENT (X=1):
    - s=0 -> HOLD, rc=1.
    - s=1 and stuck counter reaches STUCK_CYCLES-1 -> FAULT.
  - HOLD (X=1):
    - s=1 -> PRESENT (gap bridged; stuck counter restarts from 0).
    - s=0 and rc==HOLD_CYCLES-1 -> IDLE.
    - else rc++.
  - FAULT (X=1, sensor_fault=1):
    - s=0 for DEBOUNCE_CYCLES consecutive cycles -> IDLE.
    - Any s=1 restarts that count.
- Latency: X rises DEBOUNCE_CYCLES+2 edges after a clean loop_raw rise. X falls HOLD_CYCLES+2 edges after a clean loop_raw fall.
- Stuck counter (16 bit):
  - Counts cycles in PRESENT with s=1, starting from the ARM->PRESENT entry.
  - Clears on entry to HOLD or IDLE.
  - Does not count in HOLD.
- X and sensor_fault are registered, decoded from the state register, and glitch-free.
- Entering FAULT never lowers X. The controller sees a continuous vehicle, so the country road is never starved.
- Reset mid-operation (any state) returns to IDLE with X=0 immediately (asynchronous).

Optional Feature:
- Macro VEHICLE_COUNT_EN.
- Defined:
  - vehicle_count and count_clr ports exist.
  - vehicle_count increments by 1 on each ARM->PRESENT transition only. HOLD->PRESENT and FAULT do not count.
  - Saturates at all-ones.
  - count_clr=1 clears it on the next edge, with priority over a coincident increment.
- Undefined: both ports are absent and the counter logic is not built; all other behaviour is identical.

Test Plan:
- Reset: clear=0 with loop_raw=1 -> X=0, sensor_fault=0, vehicle_count=0. Release clear, hold loop_raw=1 -> X=1 exactly 6 edges later (defaults).
- Glitch rejection: loop_raw high for 3 cycles, low, repeated 5 times -> X stays 0, vehicle_count stays 0.
- Gap bridging: vehicle present, loop_raw low 2 cycles then high -> X remains 1 throughout. loop_raw low 3+ cycles -> X falls 5 edges after the fall.
- Stuck sensor with STUCK_CYCLES=20: loop_raw held high -> X=1 at edge 6, sensor_fault=1 at edge 26. loop_raw low -> sensor_fault and X clear after 6 edges.
- Counter (VEHICLE_COUNT_EN, CNT_W=2): 5 separated vehicles -> count 1,2,3,3,3. count_clr coincident with an arrival -> 0.
- Async reset mid-HOLD: clear pulses low between edges -> X=0 immediately, state IDLE, count 0.
